pmic_main: RTL and testbench

Top-level power-management controller for the PMIC FPGA board. It turns three user switches (ON/OFF, low-battery, low-power) into a staged enable pattern for four regulator rails. Rail enables are shown on `led`; the current stable mode is shown on `SSG_EN`. Rails are sequenced one at a time, so every transition is a power-up or power-down sequence, never a single-cycle jump.

---
 rtl/pmic_main.sv | 50 +++++
 tb/tb_pmic_main.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pmic_main.sv
// pmic_main: stages four regulator rails toward a switch-selected target mask, one rail per step
// Ports: clk; reset (async, active-low); on_sw, lb_sw, lp_sw (async switches);
//        led[3:0] rail enables (core, io, aux, peripheral); SSG_EN[3:0] one-hot stable mode
module pmic_main #(
  parameter int STEP_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       on_sw,
  input  logic       lb_sw,
  input  logic       lp_sw,
  output logic [3:0] led,
  output logic [3:0] SSG_EN
);
  typedef enum logic [2:0] {IDLE, SEQ, ACTIVE, LP, LB} state_t;
  logic [1:0] on_q, lb_q, lp_q;
  logic [3:0] t, dn, up, hi, r_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       step;
  state_t     st, st_nxt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      on_q <= '0;
      lb_q <= '0;
      lp_q <= '0;
      led  <= '0;
      cnt  <= '0;
      st   <= IDLE;
    end else begin
      on_q <= {on_q[0], on_sw};
      lb_q <= {lb_q[0], lb_sw};
      lp_q <= {lp_q[0], lp_sw};
      led  <= r_nxt;
      cnt  <= cnt_nxt;
      st   <= st_nxt;
    end
  always_comb begin
    t = !on_q[1] ? 4'b0000 : lb_q[1] ? 4'b0001 : lp_q[1] ? 4'b0011 : 4'b1111;
    dn = led & ~t;
    up = ~led & t;
    hi = dn[3] ? 4'b1000 : dn[2] ? 4'b0100 : dn[1] ? 4'b0010 : dn[0] ? 4'b0001 : 4'b0000;
    step = (led != t) && (cnt == 8'(STEP_CYCLES - 1));
    // power-down has priority; up & -up isolates the lowest rail still to enable
    r_nxt = step ? led ^ (|dn ? hi : (up & (~up + 4'd1))) : led;
    cnt_nxt = (led == t || step) ? 8'd0 : cnt + 8'd1;
    st_nxt = r_nxt != t ? SEQ : t == 4'b0000 ? IDLE : t == 4'b0001 ? LB : t == 4'b0011 ? LP : ACTIVE;
  end
  always_comb
    SSG_EN = st == IDLE ? 4'b0001 : st == ACTIVE ? 4'b0010 : st == LP ? 4'b0100 : st == LB ? 4'b1000 : 4'b0000;
endmodule

// File: tb/tb_pmic_main.sv
// tb_pmic_main: randomized and directed checks of pmic_main against a rule-level reference model
module tb_pmic_main;
  localparam int STEP = 3;
  logic clk = 0, reset = 0, on_sw = 0, lb_sw = 0, lp_sw = 0;
  logic [3:0] led, SSG_EN;
  int checks = 0, failures = 0;
  pmic_main #(.STEP_CYCLES(STEP)) dut (
    .clk(clk), .reset(reset), .on_sw(on_sw), .lb_sw(lb_sw), .lp_sw(lp_sw),
    .led(led), .SSG_EN(SSG_EN)
  );
  always #5 clk = ~clk;
  // target mask from the {on, lb, lp} switch triple, by priority
  function automatic logic [3:0] tgt(logic [2:0] s);
    return !s[2] ? 4'b0000 : s[1] ? 4'b0001 : s[0] ? 4'b0011 : 4'b1111;
  endfunction
  // one rail move toward t: drop the highest surplus rail, else raise the lowest missing one
  function automatic logic [3:0] step_to(logic [3:0] r, logic [3:0] t);
    for (int i = 3; i >= 0; i--) if (r[i] && !t[i]) begin r[i] = 1'b0; return r; end
    for (int i = 0; i < 4; i++) if (!r[i] && t[i]) begin r[i] = 1'b1; return r; end
    return r;
  endfunction
  function automatic logic [3:0] mode_ssg(logic [3:0] r, logic [3:0] t);
    if (r != t) return 4'b0000;
    return t == 4'b0000 ? 4'b0001 : t == 4'b1111 ? 4'b0010 : t == 4'b0011 ? 4'b0100 : 4'b1000;
  endfunction
  logic [2:0] m_s1, m_s2;
  logic [3:0] m_r, m_ssg;
  int m_cnt;
  always @(posedge clk or negedge reset)
    if (!reset) begin
      m_s1 <= '0; m_s2 <= '0; m_r <= '0; m_cnt <= 0; m_ssg <= 4'b0001;
    end else begin
      m_s1 <= {on_sw, lb_sw, lp_sw};
      m_s2 <= m_s1;
      if (m_r == tgt(m_s2)) m_cnt <= 0;
      else if (m_cnt == STEP - 1) begin
        m_cnt <= 0;
        m_r <= step_to(m_r, tgt(m_s2));
      end else m_cnt <= m_cnt + 1;
      m_ssg <= mode_ssg((m_r != tgt(m_s2) && m_cnt == STEP - 1) ? step_to(m_r, tgt(m_s2)) : m_r, tgt(m_s2));
    end

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if (led !== 4'b0000 || SSG_EN !== 4'b0001) begin
      failures++;
      $display("FAIL reset: led=%b SSG_EN=%b, required led=0000 SSG_EN=0001", led, SSG_EN);
    end
    reset = 1;
  endtask

  task automatic test_power_up;
    on_sw = 1;
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      checks++;
      if (led !== m_r || SSG_EN !== m_ssg) begin
        failures++;
        $display("FAIL power_up cycle %0d: led=%b SSG_EN=%b, model led=%b SSG_EN=%b", j, led, SSG_EN, m_r, m_ssg);
      end
      if (j == 4 || j == 5 || j == 13 || j == 14) begin
        checks++;
        if (led !== (j == 4 ? 4'b0000 : j == 5 ? 4'b0001 : j == 13 ? 4'b0111 : 4'b1111)) begin
          failures++;
          $display("FAIL power_up_timing cycle %0d: led=%b", j, led);
        end
      end
    end
    checks++;
    if (SSG_EN !== 4'b0010) begin
      failures++;
      $display("FAIL power_up_mode: SSG_EN=%b, required 0010", SSG_EN);
    end
  endtask

  task automatic test_power_down;
    on_sw = 0;
    for (int j = 1; j <= 14; j++) begin
      @(negedge clk);
      checks++;
      if (led !== m_r || SSG_EN !== m_ssg) begin
        failures++;
        $display("FAIL power_down cycle %0d: led=%b SSG_EN=%b, model led=%b SSG_EN=%b", j, led, SSG_EN, m_r, m_ssg);
      end
    end
    checks++;
    if (led !== 4'b0000 || SSG_EN !== 4'b0001) begin
      failures++;
      $display("FAIL power_down_end: led=%b SSG_EN=%b, required 0000 0001", led, SSG_EN);
    end
  endtask

  // table rows: {on, lb, lp, expected led, expected SSG_EN}
  task automatic run_table(input string name, input logic [10:0] tab[], input int hold);
    foreach (tab[k]) begin
      {on_sw, lb_sw, lp_sw} = tab[k][10:8];
      repeat (hold) begin
        @(negedge clk);
        checks++;
        if (led !== m_r || SSG_EN !== m_ssg) begin
          failures++;
          $display("FAIL %s step %0d: led=%b SSG_EN=%b, model led=%b SSG_EN=%b", name, k, led, SSG_EN, m_r, m_ssg);
        end
      end
      checks++;
      if (led !== tab[k][7:4] || SSG_EN !== tab[k][3:0]) begin
        failures++;
        $display("FAIL %s_end step %0d: led=%b SSG_EN=%b, required %b %b", name, k, led, SSG_EN, tab[k][7:4], tab[k][3:0]);
      end
    end
  endtask

  task automatic test_modes;
    logic [10:0] tab[] = '{
      {3'b100, 4'b1111, 4'b0010}, {3'b101, 4'b0011, 4'b0100}, {3'b111, 4'b0001, 4'b1000},
      {3'b101, 4'b0011, 4'b0100}, {3'b100, 4'b1111, 4'b0010}};
    run_table("modes", tab, 16);
  endtask

  task automatic test_priority;
    logic [10:0] tab[] = '{
      {3'b110, 4'b0001, 4'b1000}, {3'b111, 4'b0001, 4'b1000}, {3'b101, 4'b0011, 4'b0100},
      {3'b111, 4'b0001, 4'b1000}, {3'b110, 4'b0001, 4'b1000}, {3'b100, 4'b1111, 4'b0010}};
    run_table("priority", tab, 16);
  endtask

  task automatic test_shutdown_low;
    logic [10:0] tab[] = '{
      {3'b110, 4'b0001, 4'b1000}, {3'b010, 4'b0000, 4'b0001}, {3'b101, 4'b0011, 4'b0100},
      {3'b001, 4'b0000, 4'b0001}};
    run_table("shutdown_low", tab, 16);
  endtask

  task automatic test_reset_mid;
    int n = 0;
    on_sw = 1; lb_sw = 0; lp_sw = 0;
    while (led !== 4'b0011 && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (led !== 4'b0011) begin
      failures++;
      $display("FAIL reset_mid_wait: led=%b never reached 0011", led);
    end
    reset = 0;
    #1;
    checks++;
    if (led !== 4'b0000 || SSG_EN !== 4'b0001) begin
      failures++;
      $display("FAIL reset_mid_drop: led=%b SSG_EN=%b, required 0000 0001", led, SSG_EN);
    end
    @(negedge clk);
    reset = 1;
    for (int j = 1; j <= 14; j++) begin
      @(negedge clk);
      checks++;
      if (led !== m_r || SSG_EN !== m_ssg) begin
        failures++;
        $display("FAIL reset_mid_restart cycle %0d: led=%b SSG_EN=%b, model led=%b SSG_EN=%b", j, led, SSG_EN, m_r, m_ssg);
      end
    end
    checks++;
    if (led !== 4'b1111 || SSG_EN !== 4'b0010) begin
      failures++;
      $display("FAIL reset_mid_end: led=%b SSG_EN=%b, required 1111 0010", led, SSG_EN);
    end
  endtask

  task automatic test_random;
    for (int s = 0; s < 60; s++) begin
      on_sw = $urandom_range(0, 3) != 0;
      lb_sw = $urandom_range(0, 1) != 0;
      lp_sw = $urandom_range(0, 1) != 0;
      repeat ($urandom_range(1, 16)) begin
        @(negedge clk);
        checks++;
        if (led !== m_r || SSG_EN !== m_ssg) begin
          failures++;
          $display("FAIL random seg %0d: led=%b SSG_EN=%b, model led=%b SSG_EN=%b", s, led, SSG_EN, m_r, m_ssg);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_power_up;
    test_power_down;
    test_modes;
    test_priority;
    test_shutdown_low;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
